ysyx_bus_sched: RTL and testbench

Single-outstanding AXI4 master scheduler that shares one 64-bit memory port between the IFU (INCR line-fill bursts) and the LSU (single-beat loads/stores). It sequences AR/R and AW/W/B, steers 32-bit client data onto 64-bit lanes and applies starvation-bounded LSU-first arbitration.

---
 rtl/ysyx_bus_sched.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_bus_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_bus_sched.sv
// Single-outstanding AXI4 master shared by the IFU (INCR line fills) and the
// LSU (single-beat loads/stores). LSU requests win arbitration, except that
// after STARVE_MAX back-to-back LSU grants with a fetch waiting, the IFU goes next.
module ysyx_bus_sched #(
    parameter int BURST_LEN  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] io_master_araddr,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    input  logic [63:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic        io_master_rvalid,
    output logic [31:0] io_master_awaddr,
    output logic [2:0]  io_master_awsize,
    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [63:0] io_master_wdata,
    output logic [7:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    input  logic [1:0]  io_master_bresp,
    input  logic        io_master_bvalid,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rvalid,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        bus_err
);

    typedef enum logic [2:0] {IDLE, IF_AR, IF_R, LS_AR, LS_R, LS_WR, LS_B} state_t;

    localparam logic [7:0] IF_ARLEN   = 8'(BURST_LEN - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t      state_reg, state_next;
    logic [7:0]  starve_reg, starve_next;
    logic [31:0] addr_reg, addr_next;
    logic [1:0]  size_reg, size_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  beat_reg, beat_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;
    logic        bus_err_reg, bus_err_next;

    logic        aw_hs, w_hs;
    logic [3:0]  strb_mask, strb_shift;
    logic [31:0] wdata_shift;
    logic [31:0] load_half, load_shift;

    // State and transaction context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            starve_reg  <= '0;
            addr_reg    <= '0;
            size_reg    <= '0;
            wdata_reg   <= '0;
            beat_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            starve_reg  <= starve_next;
            addr_reg    <= addr_next;
            size_reg    <= size_next;
            wdata_reg   <= wdata_next;
            beat_reg    <= beat_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            bus_err_reg <= bus_err_next;
        end
    end

    assign aw_hs = io_master_awvalid && io_master_awready;
    assign w_hs  = io_master_wvalid && io_master_wready;

    // Arbitration, channel sequencing and client completion pulses
    always_comb begin
        state_next   = state_reg;
        starve_next  = starve_reg;
        addr_next    = addr_reg;
        size_next    = size_reg;
        wdata_next   = wdata_reg;
        beat_next    = beat_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        bus_err_next = bus_err_reg;
        ifu_rvalid   = 1'b0;
        lsu_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (lsu_req && ((starve_reg < STARVE_LIM) || !ifu_req)) begin
                    state_next   = lsu_we ? LS_WR : LS_AR;
                    starve_next  = ifu_req ? starve_reg + 8'd1 : 8'd0;
                    addr_next    = lsu_addr;
                    size_next    = lsu_size;
                    wdata_next   = lsu_wdata;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else if (ifu_req) begin
                    state_next  = IF_AR;
                    starve_next = 8'd0;
                    addr_next   = ifu_addr;
                    size_next   = 2'd2;
                    beat_next   = 4'd0;
                end
            end
            IF_AR: if (io_master_arready) state_next = IF_R;
            IF_R: begin
                if (io_master_rvalid) begin
                    ifu_rvalid = 1'b1;
                    beat_next  = beat_reg + 4'd1;
                    if (io_master_rresp != 2'b00) bus_err_next = 1'b1;
                    if (io_master_rlast) state_next = IDLE;
                end
            end
            LS_AR: if (io_master_arready) state_next = LS_R;
            LS_R: begin
                if (io_master_rvalid) begin
                    lsu_done   = 1'b1;
                    state_next = IDLE;
                    if (io_master_rresp != 2'b00) bus_err_next = 1'b1;
                end
            end
            LS_WR: begin
                // AW and W complete independently; leave once both are done
                aw_done_next = aw_done_reg || aw_hs;
                w_done_next  = w_done_reg || w_hs;
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = LS_B;
            end
            LS_B: begin
                if (io_master_bvalid) begin
                    lsu_done   = 1'b1;
                    state_next = IDLE;
                    if (io_master_bresp != 2'b00) bus_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address channels driven purely from latched context so they hold steady
    assign io_master_araddr  = addr_reg;
    assign io_master_arlen   = (state_reg == IF_AR) ? IF_ARLEN : 8'd0;
    assign io_master_arsize  = {1'b0, size_reg};
    assign io_master_arvalid = (state_reg == IF_AR) || (state_reg == LS_AR);
    assign io_master_awaddr  = addr_reg;
    assign io_master_awsize  = {1'b0, size_reg};
    assign io_master_awvalid = (state_reg == LS_WR) && !aw_done_reg;
    assign io_master_wvalid  = (state_reg == LS_WR) && !w_done_reg;
    assign io_master_wlast   = io_master_wvalid;
    assign bus_err           = bus_err_reg;

    // Byte-lane mask for the store size before positioning within the word
    always_comb begin
        case (size_reg)
            2'd0:    strb_mask = 4'b0001;
            2'd1:    strb_mask = 4'b0011;
            default: strb_mask = 4'b1111;
        endcase
    end

    assign strb_shift  = strb_mask << addr_reg[1:0];
    assign wdata_shift = wdata_reg << {addr_reg[1:0], 3'b000};

    // Store data is replicated into both 32-bit halves; strobes select the half
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign io_master_wdata[32*gi +: 32] = wdata_shift;
        assign io_master_wstrb[4*gi +: 4]   = (addr_reg[2] == (gi == 1)) ? strb_shift : 4'b0000;
    end

    // Fetch beats alternate halves as the beat address advances by 4 bytes
    assign ifu_rdata = (addr_reg[2] ^ beat_reg[0]) ? io_master_rdata[63:32] : io_master_rdata[31:0];

    assign load_half  = addr_reg[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
    assign load_shift = load_half >> {addr_reg[1:0], 3'b000};

    // Zero-extend the load to its access size
    always_comb begin
        case (size_reg)
            2'd0:    lsu_rdata = {24'd0, load_shift[7:0]};
            2'd1:    lsu_rdata = {16'd0, load_shift[15:0]};
            default: lsu_rdata = load_shift;
        endcase
    end

endmodule

// File: tb/tb_ysyx_bus_sched.sv
// Directed bench for ysyx_bus_sched: acts as the AXI slave and both clients,
// with expected values queued when stimulus is driven and popped on DUT output.
module tb_ysyx_bus_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        ifu_req;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        ifu_rvalid;
    logic        lsu_req, lsu_we;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_wdata, lsu_rdata;
    logic        lsu_done, bus_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    int          grant_q[$];

    ysyx_bus_sched #(.BURST_LEN(4), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .io_master_araddr(araddr), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arvalid(arvalid), .io_master_arready(arready),
        .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast),
        .io_master_rvalid(rvalid),
        .io_master_awaddr(awaddr), .io_master_awsize(awsize), .io_master_awvalid(awvalid),
        .io_master_awready(awready),
        .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_wvalid(wvalid), .io_master_wready(wready),
        .io_master_bresp(bresp), .io_master_bvalid(bvalid),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // sel 0 waits for arvalid, 1 for awvalid; an expired budget is a failure
    task automatic wait_valid(input int sel, input string tag);
        int n = 0;
        while (!((sel == 0) ? arvalid : awvalid) && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 20), 64'd1);
    endtask

    // Serve one read transaction; kind is 1 for an IFU burst, 0 for an LSU load
    task automatic serve_read(output int kind);
        int nbeats;
        wait_valid(0, "ar_wait");
        kind   = (arlen == 8'd0) ? 0 : 1;
        nbeats = (kind == 1) ? 4 : 1;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            rdata  = {$urandom, $urandom};
            rvalid = 1'b1;
            rlast  = (b == nbeats - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        logic [31:0] v;
        rst = 1'b1;
        arready = 0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        ifu_req = 0; ifu_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_size = 0; lsu_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_ifu_rv", 64'(ifu_rvalid), 64'd0);
        check("rst_lsu_done", 64'(lsu_done), 64'd0);
        check("rst_bus_err", 64'(bus_err), 64'd0);

        // IFU line fill from 0x30000000
        ifu_req  = 1'b1;
        ifu_addr = 32'h3000_0000;
        wait_valid(0, "if_ar_wait");
        check("if_araddr", 64'(araddr), 64'h3000_0000);
        check("if_arlen", 64'(arlen), 64'd3);
        check("if_arsize", 64'(arsize), 64'd2);
        tick();
        check("if_ar_hold", 64'(arvalid), 64'd1);
        check("if_ar_stable", 64'(araddr), 64'h3000_0000);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("if_ar_drop", 64'(arvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            v = 32'h11 * 32'(i + 1);
            exp_q.push_back(64'(v));
            rdata  = (i % 2 == 1) ? {v, 32'hDEAD_0000 + 32'(i)} : {32'hDEAD_0000 + 32'(i), v};
            rvalid = 1'b1;
            rlast  = (i == 3);
            #1;
            check("if_pulse", 64'(ifu_rvalid), 64'd1);
            check("if_data", 64'(ifu_rdata), exp_q.pop_front());
            tick();
            rvalid = 1'b0;
            rlast  = 1'b0;
            if (i == 3) ifu_req = 1'b0;
            #1;
            check("if_gap", 64'(ifu_rvalid), 64'd0);
            tick();
        end
        check("if_idle_ar", 64'(arvalid), 64'd0);

        // Load byte at 0x80000006
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0006; lsu_size = 2'd0;
        wait_valid(0, "ld_ar_wait");
        check("ld_araddr", 64'(araddr), 64'h8000_0006);
        check("ld_arlen", 64'(arlen), 64'd0);
        check("ld_arsize", 64'(arsize), 64'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rdata = 64'hAABB_CCDD_1122_3344; rvalid = 1'b1; rlast = 1'b1;
        exp_q.push_back(64'h0000_00BB);
        #1;
        check("ld_done", 64'(lsu_done), 64'd1);
        check("ld_rdata", 64'(lsu_rdata), exp_q.pop_front());
        tick();
        rvalid = 1'b0; rlast = 1'b0; lsu_req = 1'b0;
        #1;
        check("ld_done_once", 64'(lsu_done), 64'd0);

        // Stray R beat while idle produces nothing
        rvalid = 1'b1; rlast = 1'b1;
        #1;
        check("stray_ifu", 64'(ifu_rvalid), 64'd0);
        check("stray_lsu", 64'(lsu_done), 64'd0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // Store half 0xBEEF at 0x80000002, AW accepted two cycles before W
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_0002; lsu_size = 2'd1;
        lsu_wdata = 32'h0000_BEEF;
        wait_valid(1, "st_aw_wait");
        check("st_wvalid", 64'(wvalid), 64'd1);
        check("st_awaddr", 64'(awaddr), 64'h8000_0002);
        check("st_awsize", 64'(awsize), 64'd1);
        check("st_wstrb", 64'(wstrb), 64'h0C);
        check("st_wdata", wdata, 64'hBEEF_0000_BEEF_0000);
        check("st_wlast", 64'(wlast), 64'd1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("st_aw_drop", 64'(awvalid), 64'd0);
        check("st_w_hold1", 64'(wvalid), 64'd1);
        tick();
        check("st_w_hold2", 64'(wvalid), 64'd1);
        check("st_w_stable", wdata, 64'hBEEF_0000_BEEF_0000);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("st_w_drop", 64'(wvalid), 64'd0);
        check("st_no_done", 64'(lsu_done), 64'd0);
        bvalid = 1'b1;
        exp_q.push_back(64'd1);
        #1;
        check("st_done", 64'(lsu_done), exp_q.pop_front());
        tick();
        bvalid = 1'b0; lsu_req = 1'b0;
        #1;
        check("st_done_once", 64'(lsu_done), 64'd0);

        // Both clients held: LSU x3 then IFU, repeating
        for (int r = 0; r < 2; r++) begin
            grant_q.push_back(0); grant_q.push_back(0);
            grant_q.push_back(0); grant_q.push_back(1);
        end
        ifu_req = 1'b1; ifu_addr = 32'h3000_0100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0000; lsu_size = 2'd2;
        for (int k = 0; k < 8; k++) begin
            serve_read(kind);
            if (k == 7) begin
                ifu_req = 1'b0;
                lsu_req = 1'b0;
            end
            check("grant_order", 64'(kind), 64'(grant_q.pop_front()));
        end
        tick();

        // Error response on a load still completes and sets sticky bus_err
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0004; lsu_size = 2'd2;
        wait_valid(0, "err_ar_wait");
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rdata = 64'h1234_5678_9ABC_DEF0; rvalid = 1'b1; rlast = 1'b1; rresp = 2'd2;
        exp_q.push_back(64'h1234_5678);
        #1;
        check("err_done", 64'(lsu_done), 64'd1);
        check("err_rdata", 64'(lsu_rdata), exp_q.pop_front());
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; lsu_req = 1'b0;
        check("err_set", 64'(bus_err), 64'd1);
        tick(); tick(); tick();
        check("err_sticky", 64'(bus_err), 64'd1);

        // Reset in the middle of a fetch burst
        ifu_req = 1'b1; ifu_addr = 32'h3000_0004;
        wait_valid(0, "rst_ar_wait");
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rdata = 64'h0000_00AA_5555_5555; rvalid = 1'b1;
        #1;
        check("mid_pulse", 64'(ifu_rvalid), 64'd1);
        check("mid_data", 64'(ifu_rdata), 64'h0000_00AA);
        tick();
        rvalid = 1'b0;
        rst = 1'b1; ifu_req = 1'b0;
        tick();
        rst = 1'b0;
        check("post_rst_ar", 64'(arvalid), 64'd0);
        check("post_rst_err", 64'(bus_err), 64'd0);
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rlast = (i == 2);
            #1;
            check("post_rst_ifu", 64'(ifu_rvalid), 64'd0);
            check("post_rst_lsu", 64'(lsu_done), 64'd0);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
